// File: rtl/shift_issue_stage.sv
// -----------------------------------------------------------------------------
// shift_issue_stage
//
// Issue stage that sits directly in front of the barrel shifter datapath.
// Shift requests from the decode/ALU front end are buffered in a small FIFO.
// The head entry drives a combinational barrel shifter. The shifted result,
// its zero/overflow flags and the request tag are then captured in an output
// register with a valid/ready handshake. With both sides free, one op per
// cycle flows through.
//
// Ports:
//   clk_in         - clock; all state updates on the rising edge
//   rst_n_in       - asynchronous active-low reset
//   flush_in       - synchronous flush of every queued and held op
//   req_valid_in   - request valid
//   req_ready_out  - request ready (decoded from registered FIFO count only)
//   req_x_in       - operand
//   req_s_in       - shift amount
//   req_op_in      - shift op (000 LSR, 001 ASR, 01x ROR,
//                              100 LSL, 101 ASL, 11x ROL)
//   req_tag_in     - opaque request tag
//   rsp_valid_out  - result valid
//   rsp_ready_in   - result accepted by the consumer
//   rsp_y_out      - shifted result
//   rsp_zf_out     - result is zero
//   rsp_vf_out     - overflow flag from the shifter (always 0)
//   rsp_tag_out    - tag of the result
//   occupancy_out  - FIFO entry count (the output register is not counted)
//
// This file also holds the barrelshifter module that the stage instantiates.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// barrelshifter
//
// Combinational log-depth shifter. The left-shifting ops are built by
// bit-reversing the operand, running the right-shift network and reversing
// the result back. With that mapping, ASL fills from x[0] and ROL is a
// rotate-left, so one right-shift network covers all eight op codes.
//
// Ports:
//   x   - operand
//   s   - shift amount
//   op  - shift op, same encoding as the issue stage
//   y   - result
//   zf  - y == 0
//   vf  - overflow flag (shifts here never overflow, so it is tied to 0)
// -----------------------------------------------------------------------------
module barrelshifter #(
    parameter int D_SIZE = 8
) (
    input  logic [D_SIZE-1:0]         x,
    input  logic [$clog2(D_SIZE)-1:0] s,
    input  logic [2:0]                op,
    output logic [D_SIZE-1:0]         y,
    output logic                      zf,
    output logic                      vf
);

    localparam int S_W = $clog2(D_SIZE);

    function automatic logic [D_SIZE-1:0] bit_rev(input logic [D_SIZE-1:0] v);
        logic [D_SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < D_SIZE; i++) begin
            r[i] = v[D_SIZE-1-i];
        end
        return r;
    endfunction

    logic                is_left;
    logic                is_rot;
    logic                fill_bit;
    logic [D_SIZE-1:0]   norm_x;
    logic [D_SIZE-1:0]   cur;
    logic [D_SIZE-1:0]   nxt;
    logic [S_W-1:0]      src_idx;

    // Right-shift network over the (possibly reversed) operand. Each stage k
    // moves the data by 2^k when s[k] is set. Bits shifted in from the top
    // come either from the wrapped-around low bits (rotate) or from the fill
    // bit. Because D_SIZE is a power of two, truncating the source index to
    // S_W bits gives the rotate wrap for free. For ASL, the fill bit is the
    // reversed operand's MSB, which is x[0].
    always_comb begin
        is_left  = op[2];
        is_rot   = op[1];
        norm_x   = is_left ? bit_rev(x) : x;
        fill_bit = !op[1] && op[0] && norm_x[D_SIZE-1];
        cur      = norm_x;
        nxt      = '0;
        src_idx  = '0;
        for (int k = 0; k < S_W; k++) begin
            nxt = cur;
            if (s[k]) begin
                for (int i = 0; i < D_SIZE; i++) begin
                    src_idx = S_W'(i + (1 << k));
                    if ((i + (1 << k) < D_SIZE) || is_rot) begin
                        nxt[i] = cur[src_idx];
                    end else begin
                        nxt[i] = fill_bit;
                    end
                end
            end
            cur = nxt;
        end
        y  = is_left ? bit_rev(cur) : cur;
        zf = (y == '0);
        vf = 1'b0;
    end

endmodule

module shift_issue_stage #(
    parameter int D_SIZE = 8,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       flush_in,
    input  logic                       req_valid_in,
    output logic                       req_ready_out,
    input  logic [D_SIZE-1:0]          req_x_in,
    input  logic [$clog2(D_SIZE)-1:0]  req_s_in,
    input  logic [2:0]                 req_op_in,
    input  logic [TAG_W-1:0]           req_tag_in,
    output logic                       rsp_valid_out,
    input  logic                       rsp_ready_in,
    output logic [D_SIZE-1:0]          rsp_y_out,
    output logic                       rsp_zf_out,
    output logic                       rsp_vf_out,
    output logic [TAG_W-1:0]           rsp_tag_out,
    output logic [$clog2(DEPTH):0]     occupancy_out
);

    localparam int S_W   = $clog2(D_SIZE);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [D_SIZE-1:0] x;
        logic [S_W-1:0]    s;
        logic [2:0]        op;
        logic [TAG_W-1:0]  tag;
    } req_t;

    req_t              mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              push;
    logic              pop;
    logic              head_valid;
    req_t              head;
    logic [D_SIZE-1:0] shift_y;
    logic              shift_zf;
    logic              shift_vf;

    // DEPTH is a power of two, so the FIFO is full exactly when the count's
    // MSB is set. Ready comes from registered state only, so a same-cycle pop
    // cannot reopen a full FIFO, and there is no path from rsp_ready_in.
    assign req_ready_out = !count[PTR_W];
    assign head_valid    = (count != '0);
    assign push          = req_valid_in && req_ready_out;
    assign pop           = head_valid && (!rsp_valid_out || rsp_ready_in);
    assign occupancy_out = count;

    // When the FIFO is empty, drive zeros into the shifter so that stale
    // entries do not make it toggle.
    assign head = head_valid ? mem[rd_ptr] : '0;

    barrelshifter #(
        .D_SIZE (D_SIZE)
    ) u_shifter (
        .x  (head.x),
        .s  (head.s),
        .op (head.op),
        .y  (shift_y),
        .zf (shift_zf),
        .vf (shift_vf)
    );

    // FIFO storage has no reset. Only entries between rd_ptr and wr_ptr are
    // ever observed. A request pushed during a flush is dropped, so there is
    // no point writing it.
    always_ff @(posedge clk_in) begin
        if (push && !flush_in) begin
            mem[wr_ptr] <= '{x: req_x_in, s: req_s_in, op: req_op_in, tag: req_tag_in};
        end
    end

    // Pointers wrap naturally modulo DEPTH. A simultaneous push and pop
    // advances both pointers and leaves the count unchanged. Flush overrides
    // both.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register. A pop loads the shifter result together with the head
    // tag. When the consumer accepts the result and nothing is queued, valid
    // drops but the data outputs keep their last values. During a stall,
    // nothing here changes.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rsp_valid_out <= 1'b0;
            rsp_y_out     <= '0;
            rsp_zf_out    <= 1'b0;
            rsp_vf_out    <= 1'b0;
            rsp_tag_out   <= '0;
        end else if (flush_in) begin
            rsp_valid_out <= 1'b0;
        end else if (pop) begin
            rsp_valid_out <= 1'b1;
            rsp_y_out     <= shift_y;
            rsp_zf_out    <= shift_zf;
            rsp_vf_out    <= shift_vf;
            rsp_tag_out   <= head.tag;
        end else if (rsp_valid_out && rsp_ready_in) begin
            rsp_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_stage
//
// Directed and randomized bench for shift_issue_stage (D_SIZE=8, DEPTH=4,
// TAG_W=4). A transaction-level reference model holds the pending requests
// in a queue and the presented result in a few variables. Expected shift
// results come from plain arithmetic on the op definitions.
// -----------------------------------------------------------------------------
module tb_shift_issue_stage;

    localparam int D_SIZE = 8;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;

    logic       clk;
    logic       rstN;
    logic       flush;
    logic       reqValid;
    logic       reqReady;
    logic [7:0] reqX;
    logic [2:0] reqS;
    logic [2:0] reqOp;
    logic [3:0] reqTag;
    logic       rspValid;
    logic       rspReady;
    logic [7:0] rspY;
    logic       rspZf;
    logic       rspVf;
    logic [3:0] rspTag;
    logic [2:0] occupancy;

    shift_issue_stage #(
        .D_SIZE (D_SIZE),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rstN),
        .flush_in      (flush),
        .req_valid_in  (reqValid),
        .req_ready_out (reqReady),
        .req_x_in      (reqX),
        .req_s_in      (reqS),
        .req_op_in     (reqOp),
        .req_tag_in    (reqTag),
        .rsp_valid_out (rspValid),
        .rsp_ready_in  (rspReady),
        .rsp_y_out     (rspY),
        .rsp_zf_out    (rspZf),
        .rsp_vf_out    (rspVf),
        .rsp_tag_out   (rspTag),
        .occupancy_out (occupancy)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [2:0] s;
        logic [2:0] op;
        logic [3:0] tag;
    } req_t;

    req_t       modelQ[$];
    bit         modelValid;
    logic [7:0] modelY;
    logic       modelZf;
    logic [3:0] modelTag;

    int nAsserts = 0;
    int nFails   = 0;

    // Expected shift result, computed directly from each op's definition.
    function automatic logic [7:0] refShift(input logic [7:0] x, input logic [2:0] s, input logic [2:0] op);
        logic [15:0] dbl;
        logic [7:0]  r;
        int          sh;
        sh  = int'(s);
        dbl = {x, x};
        r   = 8'h00;
        casez (op)
            3'b000: r = x >> sh;
            3'b001: r = 8'($signed(x) >>> sh);
            3'b01?: begin
                dbl = dbl >> sh;
                r   = dbl[7:0];
            end
            3'b100: r = 8'(x << sh);
            3'b101: r = 8'(x << sh) | (x[0] ? 8'((1 << sh) - 1) : 8'h00);
            default: begin
                dbl = dbl << sh;
                r   = dbl[15:8];
            end
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    task automatic resetModel();
        modelQ.delete();
        modelValid = 1'b0;
        modelY     = 8'h00;
        modelZf    = 1'b0;
        modelTag   = 4'h0;
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".rsp_valid"}, 32'(rspValid), 32'(modelValid));
        checkOutput({where, ".occupancy"}, 32'(occupancy), 32'(modelQ.size()));
        checkOutput({where, ".req_ready"}, 32'(reqReady), 32'(modelQ.size() < DEPTH));
        checkOutput({where, ".rsp_y"},     32'(rspY),     32'(modelY));
        checkOutput({where, ".rsp_zf"},    32'(rspZf),    32'(modelZf));
        checkOutput({where, ".rsp_vf"},    32'(rspVf),    32'd0);
        checkOutput({where, ".rsp_tag"},   32'(rspTag),   32'(modelTag));
    endtask

    // Drive one cycle of inputs, step the model across the clock edge, and
    // compare every output one time unit after that edge.
    task automatic applyStimulus(input string where, input logic v, input logic [7:0] x,
                                 input logic [2:0] s, input logic [2:0] op, input logic [3:0] tag,
                                 input logic rdy, input logic fl);
        bit   doPush;
        bit   doPop;
        req_t r;
        reqValid = v;
        reqX     = x;
        reqS     = s;
        reqOp    = op;
        reqTag   = tag;
        rspReady = rdy;
        flush    = fl;
        doPush   = v && (modelQ.size() < DEPTH);
        doPop    = (modelQ.size() > 0) && (!modelValid || rdy);
        @(posedge clk);
        #1;
        if (fl) begin
            modelQ.delete();
            modelValid = 1'b0;
        end else begin
            if (doPop) begin
                r          = modelQ.pop_front();
                modelY     = refShift(r.x, r.s, r.op);
                modelZf    = (modelY == 8'h00);
                modelTag   = r.tag;
                modelValid = 1'b1;
            end else if (modelValid && rdy) begin
                modelValid = 1'b0;
            end
            if (doPush) begin
                r.x = x; r.s = s; r.op = op; r.tag = tag;
                modelQ.push_back(r);
            end
        end
        checkAll(where);
    endtask

    logic [7:0] dirX  [6] = '{8'hB4, 8'hB4, 8'hB4, 8'h81, 8'h81, 8'h81};
    logic [2:0] dirS  [6] = '{3'd2, 3'd2, 3'd4, 3'd1, 3'd1, 3'd1};
    logic [2:0] dirOp [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    logic [7:0] dirY  [6] = '{8'h2D, 8'hED, 8'h4B, 8'h02, 8'h03, 8'h03};

    initial begin
        rstN     = 1'b0;
        flush    = 1'b0;
        reqValid = 1'b0;
        reqX     = '0;
        reqS     = '0;
        reqOp    = '0;
        reqTag   = '0;
        rspReady = 1'b1;
        resetModel();
        #12;
        checkAll("reset");
        @(negedge clk);
        rstN = 1'b1;

        // Single ops from the directed table; each result is due one edge
        // after its push edge.
        for (int i = 0; i < 6; i++) begin
            applyStimulus("dir_push", 1'b1, dirX[i], dirS[i], dirOp[i], 4'(i), 1'b1, 1'b0);
            checkOutput("dir_valid_at_push", 32'(rspValid), 32'd0);
            applyStimulus("dir_result", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);
            checkOutput("dir_y",     32'(rspY),     32'(dirY[i]));
            checkOutput("dir_valid", 32'(rspValid), 32'd1);
            checkOutput("dir_zf",    32'(rspZf),    32'd0);
            checkOutput("dir_tag",   32'(rspTag),   32'(i));
        end

        // A result of zero raises the zero flag.
        applyStimulus("zero_push", 1'b1, 8'h01, 3'd1, 3'b000, 4'hA, 1'b1, 1'b0);
        applyStimulus("zero_result", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);
        checkOutput("zero_y",   32'(rspY),   32'h00);
        checkOutput("zero_zf",  32'(rspZf),  32'd1);
        checkOutput("zero_tag", 32'(rspTag), 32'hA);
        applyStimulus("zero_drain", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);

        // Back-pressure: the sixth push is refused, and the head result holds.
        for (int t = 0; t < 6; t++) begin
            applyStimulus("stall_push", 1'b1, 8'($urandom), 3'($urandom), 3'($urandom), 4'(t), 1'b0, 1'b0);
        end
        checkOutput("stall_occ",   32'(occupancy), 32'd4);
        checkOutput("stall_ready", 32'(reqReady),  32'd0);
        checkOutput("stall_tag",   32'(rspTag),    32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus("release", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);
            checkOutput("release_tag", 32'(rspTag), 32'(k + 1));
        end
        applyStimulus("release_drain", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);
        checkOutput("release_drained", 32'(rspValid), 32'd0);

        // Streaming with a consumer that is always ready.
        for (int i = 0; i < 20; i++) begin
            applyStimulus("stream", 1'b1, 8'($urandom), 3'($urandom), 3'($urandom), 4'(i), 1'b1, 1'b0);
            checkOutput("stream_occ_le1", 32'(occupancy <= 3'd1), 32'd1);
            if (i > 0) checkOutput("stream_no_bubble", 32'(rspValid), 32'd1);
        end
        applyStimulus("stream_tail", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);
        applyStimulus("stream_idle", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);

        // Flush with three entries queued and a result held; the flush also
        // discards a same-cycle push.
        for (int i = 0; i < 4; i++) begin
            applyStimulus("flush_fill", 1'b1, 8'($urandom), 3'($urandom), 3'($urandom), 4'(i), 1'b0, 1'b0);
        end
        checkOutput("flush_pre_occ",   32'(occupancy), 32'd3);
        checkOutput("flush_pre_valid", 32'(rspValid),  32'd1);
        applyStimulus("flush", 1'b1, 8'h55, 3'd1, 3'b000, 4'hF, 1'b1, 1'b1);
        checkOutput("flush_occ",   32'(occupancy), 32'd0);
        checkOutput("flush_valid", 32'(rspValid),  32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("post_flush", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);
            checkOutput("post_flush_valid", 32'(rspValid), 32'd0);
        end

        // Randomized traffic with back-pressure and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            applyStimulus("random",
                          1'($urandom_range(0, 3) != 0),
                          8'($urandom), 3'($urandom), 3'($urandom), 4'($urandom),
                          1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset between clock edges, with ops in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("pre_reset", 1'b1, 8'($urandom), 3'($urandom), 3'($urandom), 4'(i + 8), 1'b0, 1'b0);
        end
        reqValid = 1'b0;
        #3;
        rstN = 1'b0;
        #1;
        resetModel();
        checkAll("async_reset");
        checkOutput("async_reset_valid", 32'(rspValid),  32'd0);
        checkOutput("async_reset_occ",   32'(occupancy), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus("after_reset_push", 1'b1, 8'hB4, 3'd2, 3'b000, 4'h3, 1'b1, 1'b0);
        applyStimulus("after_reset_result", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);
        checkOutput("after_reset_y",   32'(rspY),   32'h2D);
        checkOutput("after_reset_tag", 32'(rspTag), 32'h3);
        applyStimulus("after_reset_drain", 1'b0, 8'h00, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Issue stage directly upstream of the barrel shifter datapath.
- Buffers shift requests from the decode/ALU front end in a small FIFO and presents the head entry to an instantiated barrelshifter.
- Registers the shifted result, zero flag and overflow flag with their request tag into an output register with a valid/ready handshake.
- Decouples the combinational shifter from upstream stalls and downstream back-pressure at a sustained throughput of one op per cycle.

Parameters:
- D_SIZE, 8: data width; passed to barrelshifter; power of 2, ≥ 2.
- DEPTH, 4: request FIFO entries; power of 2, ≥ 2.
- TAG_W, 4: width of the opaque request tag carried alongside each op.

Ports:
- clk_in  input  1  clock, all state on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- flush_in  input  1  synchronous flush of all queued and held ops.
- req_valid_in  input  1  request valid.
- req_ready_out  output  1  request ready.
- req_x_in  input  D_SIZE  operand.
- req_s_in  input  $clog2(D_SIZE)  shift amount.
- req_op_in  input  3  shift op, barrelshifter encoding.
- req_tag_in  input  TAG_W  request tag.
- rsp_valid_out  output  1  result valid.
- rsp_ready_in  input  1  result accepted by consumer.
- rsp_y_out  output  D_SIZE  shifted result.
- rsp_zf_out  output  1  result == 0.
- rsp_vf_out  output  1  overflow flag from shifter (always 0).
- rsp_tag_out  output  TAG_W  tag of the result.
- occupancy_out  output  $clog2(DEPTH)+1  FIFO entry count, output register excluded.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - FIFO pointers and count = 0.
  - rsp_valid_out = 0; rsp_y_out, rsp_zf_out, rsp_vf_out, rsp_tag_out = 0.
  - occupancy_out = 0; req_ready_out = 1 once reset deasserts.
- Op encoding, applied exactly as the shifter defines it:
  - 000 LSR, 001 ASR (fill with x[D_SIZE-1]), 01x ROR.
  - 100 LSL, 101 ASL (bit-reversed ASR: fill with x[0]), 11x ROL.
  - All 8 codes are legal.
- Push: occurs when req_valid_in && req_ready_out.
  - req_ready_out = (count < DEPTH), decoded from registered state only.
  - No combinational path from rsp_ready_in to req_ready_out.
  - When full, ready stays 0 even if a pop occurs in the same cycle (no full-cycle bypass).
- Head: when count > 0, the head entry's x/s/op drive the barrelshifter combinationally.
- Pop / load: occurs when count > 0 && (!rsp_valid_out || rsp_ready_in).
  - On that edge the output register captures y, zf, vf and the head tag; rsp_valid_out = 1; the FIFO head advances.
- Drain: when rsp_valid_out && rsp_ready_in && count == 0, rsp_valid_out goes to 0; data outputs hold their last values.
- Stall: while rsp_valid_out && !rsp_ready_in, all rsp_* outputs are held stable.
- Simultaneous push and pop: count unchanged; both pointers advance; they wrap modulo DEPTH.
- Latency: a request pushed at edge E0 appears at rsp_valid_out after edge E1 (E0+1) at the earliest.
- Ordering: strict FIFO; no reordering; the tag passes through unchanged.
- flush_in = 1 at an edge:
  - Count goes to 0, pointers go to 0, rsp_valid_out goes to 0.
  - Flush wins over a same-cycle push and pop; the pushed request is discarded.
  - req_ready_out still reflects pre-flush state during the flush cycle.
- occupancy_out: equals the registered count.
- Reset mid-operation: all in-flight ops are lost; the state above applies immediately on assertion.

Test Plan:
- D_SIZE=8, rsp_ready_in=1, push single ops:
  - LSR x=0xB4 s=2 → y=0x2D.
  - ASR 0xB4 s=2 → y=0xED.
  - ROR 0xB4 s=4 → y=0x4B.
  - LSL 0x81 s=1 → y=0x02.
  - ASL 0x81 s=1 → y=0x03.
  - ROL 0x81 s=1 → y=0x03.
  - Each op: rsp_valid_out rises exactly 1 edge after the push edge; zf=0, vf=0.
- LSR x=0x01 s=1, tag=0xA → y=0x00, zf=1, tag_out=0xA.
- rsp_ready_in=0, push tags 0..5 back to back:
  - 5 pushes are accepted (1 in the output register + 4 in the FIFO); req_ready_out=0 on the 6th.
  - occupancy_out=4.
  - rsp_* outputs stay stable at tag 0 throughout.
  - Then assert rsp_ready_in=1: tags 0..4 emerge on consecutive cycles in order.
- Streaming: continuous req_valid_in with rsp_ready_in=1 for 20 ops → one result per cycle, no bubbles, occupancy_out ≤ 1.
- With 3 entries queued and rsp_valid_out=1, assert flush_in together with a push:
  - Next cycle: occupancy_out=0, rsp_valid_out=0.
  - The pushed op never appears at the output.
- Assert rst_n_in low mid-stream, asynchronously between edges:
  - Outputs go to reset values immediately.
  - After release, the first new request produces a correct result with no stale data.
